// File: rtl/rosc_entropy_sampler_pkg.sv
// rtl/rosc_entropy_sampler_pkg.sv - shared encodings and defaults for the ring-oscillator entropy sampler
package rosc_entropy_sampler_pkg;

  localparam int WORD_W                = 32;
  localparam int BIT_CNT_W             = 6;
  localparam int SAMPLE_CNT_W          = 8;
  localparam int STUCK_CNT_W           = 8;
  localparam int SAMPLE_CYCLES_DEFAULT = 16;
  localparam int STUCK_LIMIT_DEFAULT   = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/rosc_bit_sync.sv
// rtl/rosc_bit_sync.sv - two-flop synchronizer for the free-running oscillator output
module rosc_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_bit,
  output logic sync_bit
);

  (* preserve, async_reg = "true" *) logic meta;
  (* preserve, async_reg = "true" *) logic stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
    end else begin
      meta   <= async_bit;
      stable <= meta;
    end
  end

  assign sync_bit = stable;

endmodule

// File: rtl/rosc_entropy_sampler.sv
// rtl/rosc_entropy_sampler.sv - samples a ring oscillator, von Neumann debiases it and packs 32-bit words
module rosc_entropy_sampler
  import rosc_entropy_sampler_pkg::*;
#(
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEFAULT,
  parameter int STUCK_LIMIT   = STUCK_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rosc_bit,
  output logic [WORD_W-1:0] entropy_data,
  output logic              entropy_valid,
  input  logic              entropy_ack,
  output logic              stuck_alarm
);

  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LAST = SAMPLE_CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [STUCK_CNT_W-1:0]  STUCK_MAX   = STUCK_CNT_W'(STUCK_LIMIT);
  localparam logic [BIT_CNT_W-1:0]    LAST_BIT    = BIT_CNT_W'(WORD_W - 1);

  state_t                  state;
  state_t                  next_state;
  logic                    sync_bit;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;
  logic                    pair_have;
  logic                    pair_first;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]       shift_reg;
  logic [WORD_W-1:0]       shift_next;
  logic [STUCK_CNT_W-1:0]  stuck_cnt;
  logic [STUCK_CNT_W-1:0]  stuck_next;
  logic                    have_prev;
  logic                    prev_sample;
  logic                    sample_tick;
  logic                    accept;
  logic                    word_done;
  logic                    ack_take;

  rosc_bit_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .async_bit (rosc_bit),
    .sync_bit  (sync_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    sample_tick = 1'b0;
    accept      = 1'b0;
    word_done   = 1'b0;
    ack_take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        sample_tick = (sample_cnt == SAMPLE_LAST);
        accept      = sample_tick && pair_have && (pair_first != sync_bit);
        word_done   = accept && (bit_cnt == LAST_BIT);
        if (word_done) next_state = ST_FULL;
      end
      ST_FULL: begin
        // Sampling keeps running here only so the stuck monitor stays live.
        sample_tick = (sample_cnt == SAMPLE_LAST);
        ack_take    = entropy_ack;
        if (entropy_ack) next_state = ST_COLLECT;
      end
      default: next_state = ST_IDLE;
    endcase
    if (!enable) begin
      next_state  = ST_IDLE;
      sample_tick = 1'b0;
      accept      = 1'b0;
      word_done   = 1'b0;
      ack_take    = 1'b0;
    end
    entropy_valid = (state == ST_FULL);
  end

  // Pair 01 yields 0 and 10 yields 1, so the accepted bit is always the first sample.
  assign shift_next = {shift_reg[WORD_W-2:0], pair_first};

  always_comb begin
    stuck_next = STUCK_CNT_W'(1);
    if (have_prev && (sync_bit == prev_sample)) begin
      stuck_next = (stuck_cnt >= STUCK_MAX) ? STUCK_MAX : stuck_cnt + STUCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt  <= '0;
      pair_have   <= 1'b0;
      pair_first  <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      stuck_cnt   <= '0;
      have_prev   <= 1'b0;
      prev_sample <= 1'b0;
      stuck_alarm <= 1'b0;
    end else if (!enable) begin
      sample_cnt  <= '0;
      pair_have   <= 1'b0;
      pair_first  <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      stuck_cnt   <= '0;
      have_prev   <= 1'b0;
      prev_sample <= 1'b0;
      stuck_alarm <= 1'b0;
    end else begin
      if (ack_take) begin
        sample_cnt <= '0;
        pair_have  <= 1'b0;
        bit_cnt    <= '0;
        shift_reg  <= '0;
      end else if (state != ST_IDLE) begin
        sample_cnt <= sample_tick ? '0 : sample_cnt + SAMPLE_CNT_W'(1);
        if ((state == ST_COLLECT) && sample_tick) begin
          if (!pair_have) begin
            pair_have  <= 1'b1;
            pair_first <= sync_bit;
          end else begin
            pair_have <= 1'b0;
            if (accept) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
      end
      if (sample_tick) begin
        stuck_cnt   <= stuck_next;
        have_prev   <= 1'b1;
        prev_sample <= sync_bit;
        if (stuck_next >= STUCK_MAX) stuck_alarm <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entropy_data <= '0;
    end else if (word_done) begin
      entropy_data <= shift_next;
    end
  end

endmodule

// File: tb/tb_rosc_entropy_sampler.sv
// tb/tb_rosc_entropy_sampler.sv - directed self-checking bench for rosc_entropy_sampler
module tb_rosc_entropy_sampler;

  localparam int SC = 4;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rosc_bit;
  logic        entropy_ack;
  logic [31:0] entropy_data;
  logic        entropy_valid;
  logic        stuck_alarm;

  int errors = 0;
  int checks = 0;

  rosc_entropy_sampler #(
    .SAMPLE_CYCLES (SC),
    .STUCK_LIMIT   (SL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .rosc_bit      (rosc_bit),
    .entropy_data  (entropy_data),
    .entropy_valid (entropy_valid),
    .entropy_ack   (entropy_ack),
    .stuck_alarm   (stuck_alarm)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read there too.
  task automatic send_sample(input logic b);
    rosc_bit = b;
    repeat (SC) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pair(input logic b);
    send_sample(b);
    send_sample(~b);
  endtask

  task automatic start_collect;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic collect_word(input logic [31:0] w, input int junk_every, input int ack_at,
                              input string tag);
    logic jb;
    for (int i = 31; i >= 0; i--) begin
      if (junk_every > 0 && (i % junk_every) == 0) begin
        jb = ((i / junk_every) % 2) == 1;
        send_sample(jb);
        send_sample(jb);
      end
      if (i == 0) begin
        checks++;
        if (entropy_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_early_valid: got %b want 0", tag, entropy_valid);
        end
      end
      if (i == ack_at) entropy_ack = 1'b1;
      send_pair(w[i]);
      entropy_ack = 1'b0;
    end
    checks++;
    if (entropy_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b want 1", tag, entropy_valid);
    end
    checks++;
    if (entropy_data !== w) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", tag, entropy_data, w);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; rosc_bit = 1'b0; entropy_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (entropy_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", entropy_data);
    end
    checks++;
    if (entropy_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", entropy_valid);
    end
    checks++;
    if (stuck_alarm !== 1'b0) begin
      errors++; $display("FAIL reset_alarm: got %b want 0", stuck_alarm);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_ignored_idle;
    entropy_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    entropy_ack = 1'b0;
    checks++;
    if (entropy_valid !== 1'b0) begin
      errors++; $display("FAIL ack_idle_valid: got %b want 0", entropy_valid);
    end
  endtask

  task automatic test_alternating;
    start_collect();
    collect_word(32'h5555_5555, 0, 16, "alternating");
  endtask

  task automatic test_hold_ack;
    int bad_data = 0;
    int bad_valid = 0;
    for (int c = 0; c < 100; c++) begin
      rosc_bit = c[2];
      @(posedge clk);
      @(negedge clk);
      if (entropy_data !== 32'h5555_5555) bad_data++;
      if (entropy_valid !== 1'b1) bad_valid++;
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL hold_data_stable: got %0d changed cycles want 0", bad_data);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++; $display("FAIL hold_valid: got %0d low cycles want 0", bad_valid);
    end
    entropy_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    entropy_ack = 1'b0;
    checks++;
    if (entropy_valid !== 1'b0) begin
      errors++; $display("FAIL ack_valid_drop: got %b want 0", entropy_valid);
    end
    checks++;
    if (entropy_data !== 32'h5555_5555) begin
      errors++; $display("FAIL ack_data_retained: got %h want 55555555", entropy_data);
    end
    collect_word(32'h3C96_0FA1, 0, -1, "after_ack");
  endtask

  task automatic test_enable_drop_in_full;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (entropy_valid !== 1'b0) begin
      errors++; $display("FAIL enable_drop_valid: got %b want 0", entropy_valid);
    end
    start_collect();
  endtask

  task automatic test_discard_pairs;
    collect_word(32'hFFFF_FFFF, 4, -1, "discard_pairs");
  endtask

  task automatic test_stuck;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_collect();
    for (int k = 0; k < 7; k++) send_sample(1'b1);
    checks++;
    if (stuck_alarm !== 1'b0) begin
      errors++; $display("FAIL stuck_before_limit: got %b want 0", stuck_alarm);
    end
    send_sample(1'b1);
    checks++;
    if (stuck_alarm !== 1'b1) begin
      errors++; $display("FAIL stuck_at_limit: got %b want 1", stuck_alarm);
    end
    for (int k = 0; k < 8; k++) send_sample(1'b1);
    checks++;
    if (entropy_valid !== 1'b0 || stuck_alarm !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got valid=%b alarm=%b want valid=0 alarm=1", entropy_valid, stuck_alarm);
    end
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (stuck_alarm !== 1'b0) begin
      errors++; $display("FAIL stuck_clear: got %b want 0", stuck_alarm);
    end
    start_collect();
  endtask

  task automatic test_reset_mid_word;
    for (int k = 0; k < 20; k++) send_pair(1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if (entropy_data !== 32'h0 || entropy_valid !== 1'b0 || stuck_alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got data=%h valid=%b alarm=%b want 0/0/0", entropy_data, entropy_valid, stuck_alarm);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (entropy_data !== 32'h0 || entropy_valid !== 1'b0 || stuck_alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: got data=%h valid=%b alarm=%b want 0/0/0", entropy_data, entropy_valid, stuck_alarm);
    end
    reset = 1'b0;
    start_collect();
    collect_word(32'hA5A5_A5A5, 0, -1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_ack_ignored_idle();
    test_alternating();
    test_hold_ack();
    test_enable_drop_in_full();
    test_discard_pairs();
    test_stuck();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
